bit_rotate_pick_cnt: RTL and testbench

// - Bit-vector utility for the issue schedulers: one-hot-controlled barrel rotate

---
 rtl/bit_rotate_pick_cnt_pkg.sv | 16 +
 rtl/bit_rotate_pick_cnt_if.sv | 35 +++
 rtl/bit_rotate_pick_cnt_rotate_oh.sv | 33 +++
 rtl/bit_rotate_pick_cnt.sv | 73 +++++++
 tb/tb_bit_rotate_pick_cnt.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/bit_rotate_pick_cnt_pkg.sv
// Shared types and constants for the rotate/pick/count utility.
// Direction selectors and the default count type.
package bit_rotate_pick_cnt_pkg;

    localparam int WIDTH_DEF = 32;

    localparam bit DIR_RIGHT = 1'b0;
    localparam bit DIR_LEFT  = 1'b1;

    typedef logic [$clog2(WIDTH_DEF):0] cnt_t;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/bit_rotate_pick_cnt_if.sv
// Request/result bundle for bit_rotate_pick_cnt.
// Master drives requests, slave returns results.
interface bit_rotate_pick_cnt_if
    import bit_rotate_pick_cnt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    localparam int CW = cnt_w(WIDTH);

    logic             i_valid;
    logic [WIDTH-1:0] i_in;
    logic [WIDTH-1:0] i_sel;
    logic [WIDTH-1:0] o_rshift;
    logic [WIDTH-1:0] o_lshift;
    logic [WIDTH-1:0] o_pick_oh;
    logic [CW-1:0]    o_cnt;
    logic [WIDTH-1:0] o_pick_oh_q;
    logic [CW-1:0]    o_cnt_q;
    logic             o_valid_q;

    modport master (
        output i_valid, i_in, i_sel,
        input  o_rshift, o_lshift, o_pick_oh,
        input  o_cnt, o_pick_oh_q, o_cnt_q,
        input  o_valid_q
    );

    modport slave (
        input  i_valid, i_in, i_sel,
        output o_rshift, o_lshift, o_pick_oh,
        output o_cnt, o_pick_oh_q, o_cnt_q,
        output o_valid_q
    );

endinterface

// File: rtl/bit_rotate_pick_cnt_rotate_oh.sv
// One-hot controlled barrel rotate (AND-OR mux).
// Extra select bits OR their rotations together.
module bit_rotate_oh
    import bit_rotate_pick_cnt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter bit DIR   = DIR_RIGHT
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] i_sel,
    output logic [WIDTH-1:0] o_out
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] sh;

    // OR together the rotation for every set select bit
    always_comb begin
        dbl   = {i_in, i_in};
        sh    = '0;
        o_out = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (DIR == DIR_LEFT) begin
                sh = dbl << k;
                if (i_sel[k]) o_out = o_out | sh[2*WIDTH-1:WIDTH];
            end else begin
                sh = dbl >> k;
                if (i_sel[k]) o_out = o_out | sh[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/bit_rotate_pick_cnt.sv
// Rotates, age-ordered pick and popcount for issue schedulers.
// Pick and count are also registered for the next stage.
module bit_rotate_pick_cnt
    import bit_rotate_pick_cnt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    bit_rotate_pick_cnt_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] r_pick;
    logic [WIDTH-1:0] p_low;
    logic [CW-1:0]    cnt;

    bit_rotate_oh #(.WIDTH(WIDTH), .DIR(DIR_RIGHT)) u_rsh (
        .i_in  (bus.i_in),
        .i_sel (bus.i_sel),
        .o_out (bus.o_rshift)
    );

    bit_rotate_oh #(.WIDTH(WIDTH), .DIR(DIR_LEFT)) u_lsh (
        .i_in  (bus.i_in),
        .i_sel (bus.i_sel),
        .o_out (bus.o_lshift)
    );

    bit_rotate_oh #(.WIDTH(WIDTH), .DIR(DIR_RIGHT)) u_prsh (
        .i_in  (bus.i_in),
        .i_sel (bus.i_sel),
        .o_out (r_pick)
    );

    // Isolate the lowest set bit of the pointer-aligned vector
    always_comb begin
        p_low = r_pick & (~r_pick + WIDTH'(1));
    end

    bit_rotate_oh #(.WIDTH(WIDTH), .DIR(DIR_LEFT)) u_plsh (
        .i_in  (p_low),
        .i_sel (bus.i_sel),
        .o_out (bus.o_pick_oh)
    );

    // Population count of the request vector
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(bus.i_in[i]);
        end
    end

    assign bus.o_cnt = cnt;

    // Capture pick/count on valid; valid flag follows every cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_pick_oh_q <= '0;
            bus.o_cnt_q     <= '0;
            bus.o_valid_q   <= 1'b0;
        end else begin
            bus.o_valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                bus.o_pick_oh_q <= bus.o_pick_oh;
                bus.o_cnt_q     <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_bit_rotate_pick_cnt.sv
// Directed and exhaustive checks for bit_rotate_pick_cnt.
// WIDTH=8 with a loop-based golden model.
module tb_bit_rotate_pick_cnt;

    localparam int W = 8;

    logic i_clk;
    logic i_reset_n;
    int   tests;
    int   fails;

    bit_rotate_pick_cnt_if #(.WIDTH(W)) bus ();

    bit_rotate_pick_cnt #(.WIDTH(W)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_r(input logic [W-1:0] x,
                                         input int k);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) y[i] = x[(i + k) % W];
        return y;
    endfunction

    function automatic logic [W-1:0] m_l(input logic [W-1:0] x,
                                         input int k);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) y[i] = x[(i - k + W) % W];
        return y;
    endfunction

    function automatic logic [W-1:0] m_pick(input logic [W-1:0] x,
                                            input int k);
        logic [W-1:0] y;
        y = '0;
        for (int j = W - 1; j >= 0; j--) begin
            if (x[(k + j) % W]) begin
                y = '0;
                y[(k + j) % W] = 1'b1;
            end
        end
        return y;
    endfunction

    function automatic int m_cnt(input logic [W-1:0] x);
        int c;
        c = 0;
        for (int i = 0; i < W; i++) c += int'(x[i]);
        return c;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        i_reset_n   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_in    = '0;
        bus.i_sel   = '0;
        #1;
        chk("rst_pick_q", 32'(bus.o_pick_oh_q), 32'h0);
        chk("rst_cnt_q", 32'(bus.o_cnt_q), 32'h0);
        chk("rst_valid_q", 32'(bus.o_valid_q), 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        bus.i_in  = 8'b1000_0001;
        bus.i_sel = 8'b0000_0100;
        #1;
        chk("t1_rsh", 32'(bus.o_rshift), 32'h60);
        chk("t1_lsh", 32'(bus.o_lshift), 32'h06);

        @(negedge i_clk);
        bus.i_in    = 8'b0010_0010;
        bus.i_sel   = 8'b0000_1000;
        bus.i_valid = 1'b1;
        #1;
        chk("t2_pick", 32'(bus.o_pick_oh), 32'h20);
        chk("t2_cnt", 32'(bus.o_cnt), 32'd2);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        chk("t2_pick_q", 32'(bus.o_pick_oh_q), 32'h20);
        chk("t2_cnt_q", 32'(bus.o_cnt_q), 32'd2);
        chk("t2_valid_q", 32'(bus.o_valid_q), 32'd1);

        bus.i_in  = 8'hFF;
        bus.i_sel = 8'h01;
        #1;
        chk("t3_rsh", 32'(bus.o_rshift), 32'hFF);
        chk("t3_lsh", 32'(bus.o_lshift), 32'hFF);
        chk("t3_pick", 32'(bus.o_pick_oh), 32'h01);
        chk("t3_cnt", 32'(bus.o_cnt), 32'd8);

        bus.i_in  = 8'h00;
        bus.i_sel = 8'h10;
        #1;
        chk("t4_pick", 32'(bus.o_pick_oh), 32'h0);
        chk("t4_cnt", 32'(bus.o_cnt), 32'd0);
        bus.i_in  = 8'h5A;
        bus.i_sel = 8'h00;
        #1;
        chk("t4_rsh0", 32'(bus.o_rshift), 32'h0);
        chk("t4_lsh0", 32'(bus.o_lshift), 32'h0);
        chk("t4_pick0", 32'(bus.o_pick_oh), 32'h0);

        @(negedge i_clk);
        bus.i_in    = 8'h0F;
        bus.i_sel   = 8'h01;
        bus.i_valid = 1'b1;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        bus.i_in    = 8'hE0;
        bus.i_sel   = 8'h02;
        @(negedge i_clk);
        chk("t5_hold_cnt", 32'(bus.o_cnt_q), 32'd4);
        chk("t5_hold_pick", 32'(bus.o_pick_oh_q), 32'h01);
        chk("t5_valid_q0", 32'(bus.o_valid_q), 32'd0);
        bus.i_valid = 1'b1;
        @(negedge i_clk);
        chk("t5_valid_q1", 32'(bus.o_valid_q), 32'd1);
        chk("t5_cap_cnt", 32'(bus.o_cnt_q), 32'd3);
        i_reset_n = 1'b0;
        #1;
        chk("t5_ar_pick", 32'(bus.o_pick_oh_q), 32'h0);
        chk("t5_ar_cnt", 32'(bus.o_cnt_q), 32'h0);
        chk("t5_ar_valid", 32'(bus.o_valid_q), 32'h0);
        @(negedge i_clk);
        i_reset_n   = 1'b1;
        bus.i_valid = 1'b0;

        for (int x = 0; x < 256; x++) begin
            for (int k = 0; k < W; k++) begin
                bus.i_in  = 8'(x);
                bus.i_sel = 8'(1 << k);
                #1;
                chk("sw_rsh", 32'(bus.o_rshift),
                    32'(m_r(8'(x), k)));
                chk("sw_lsh", 32'(bus.o_lshift),
                    32'(m_l(8'(x), k)));
                chk("sw_pick", 32'(bus.o_pick_oh),
                    32'(m_pick(8'(x), k)));
                chk("sw_cnt", 32'(bus.o_cnt),
                    32'(m_cnt(8'(x))));
                chk("sw_inv", 32'(m_l(bus.o_rshift, k)),
                    32'(x));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
